// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the wait-state data memory
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dm_state_e;

    localparam int CNT_W = 4;

    function automatic int be_w(input int dasize);
        return dasize / 8;
    endfunction

endpackage

// File: rtl/dm_array.sv
// rtl/dm_array.sv - single-port word storage with byte write enables and registered read
module dm_array
    import dm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int IDX_W = 16,
    parameter int DEPTH = 65536
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [be_w(DW)-1:0]  be,
    input  logic [IDX_W-1:0]     idx,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dout
);

    localparam int BE_W = be_w(DW);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] merged;

    // dout returns the word as it will be stored, giving write-through responses
    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= merged;
            end
            dout <= merged;
        end
    end

endmodule

// File: rtl/dm_ws.sv
// rtl/dm_ws.sv - data memory with configurable wait states, byte enables and range error
module dm_ws
    import dm_pkg::*;
#(
    parameter int ADSize      = 16,
    parameter int DASize      = 32,
    parameter int DEPTH       = 65536,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    DM_enable,
    input  logic                    DM_write,
    input  logic [ADSize-1:0]       DM_address,
    input  logic [DASize-1:0]       DM_in,
    input  logic [be_w(DASize)-1:0] DM_byte_en,
    output logic [DASize-1:0]       DM_out,
    output logic                    DM_ready,
    output logic                    DM_error
);

    localparam int BE_W  = be_w(DASize);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dm_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADSize-1:0] addr_q;
    logic              wr_q;
    logic [DASize-1:0] din_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;
    logic              zero_q;
    logic [DASize-1:0] arr_dout;

    logic              accept;
    logic              access;
    logic              in_range;
    logic [ADSize-1:0] cur_addr;
    logic              cur_wr;
    logic [DASize-1:0] cur_din;
    logic [BE_W-1:0]   cur_be;

    assign accept = (state == IDLE) && DM_enable;
    assign access = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == '0));

    // Zero-wait accesses happen on the accepting edge, before the request registers load
    assign cur_addr = (state == IDLE) ? DM_address : addr_q;
    assign cur_wr   = (state == IDLE) ? DM_write   : wr_q;
    assign cur_din  = (state == IDLE) ? DM_in      : din_q;
    assign cur_be   = (state == IDLE) ? DM_byte_en : be_q;
    assign in_range = 32'(cur_addr) < DEPTH;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (DM_enable) begin
                    if (WAIT_STATES > 0) begin
                        state_n = WAIT;
                        cnt_n   = WS_INIT;
                    end else begin
                        state_n = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            din_q  <= '0;
            be_q   <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= DM_address;
                wr_q   <= DM_write;
                din_q  <= DM_in;
                be_q   <= DM_byte_en;
            end
            if (access) begin
                err_q  <= !in_range;
                zero_q <= !in_range;
            end
        end
    end

    dm_array #(
        .DW    (DASize),
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .en   (access && in_range),
        .we   (cur_wr),
        .be   (cur_be),
        .idx  (cur_addr[IDX_W-1:0]),
        .din  (cur_din),
        .dout (arr_dout)
    );

    // The array output register is not reset, so a reset or range error masks it to zero
    assign DM_out   = zero_q ? '0 : arr_dout;
    assign DM_ready = (state == RESP);
    assign DM_error = (state == RESP) && err_q;

endmodule

// File: tb/tb_dm_ws.sv
// tb/tb_dm_ws.sv - scoreboard bench for dm_ws at 0, 1 and 3 wait states
module tb_dm_ws;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        en   [3];
    logic        wr   [3];
    logic [15:0] addr [3];
    logic [31:0] din  [3];
    logic [3:0]  be   [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        err  [3];

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_ws #(
            .ADSize      (16),
            .DASize      (32),
            .DEPTH       (1000),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .DM_enable  (en[g]),
            .DM_write   (wr[g]),
            .DM_address (addr[g]),
            .DM_in      (din[g]),
            .DM_byte_en (be[g]),
            .DM_out     (dout[g]),
            .DM_ready   (rdy[g]),
            .DM_error   (err[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdy[k] === 1'b1) begin
                if (sbq.size() == 0 || sbq[0].inst != k) begin
                    chk($sformatf("spurious_rdy%0d", k), {31'b0, rdy[k]}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("data%0d", k), dout[k], mon_e.data);
                    chk($sformatf("err%0d", k), {31'b0, err[k]}, {31'b0, mon_e.err});
                    chk($sformatf("lat%0d", k), cyc - mon_e.acc, ws_of(k));
                end
            end
        end
    end

    // Inputs are scrambled right after acceptance to show the captured request is used
    task automatic issue(input int k, input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] ed, input logic ee, input logic hold);
        en[k] = 1'b1; wr[k] = w; addr[k] = a; din[k] = d; be[k] = b;
        @(posedge clk); #1;
        sbq.push_back('{k, ed, ee, cyc});
        prev_acc = last_acc;
        last_acc = cyc;
        en[k] = hold; wr[k] = ~w; addr[k] = ~a; din[k] = ~d; be[k] = ~b;
        for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        if (sbq.size() > 0) begin
            chk("timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; en[k] = 1'b1; wr[k] = 1'b1;
            addr[k] = 16'd5; din[k] = 32'hDEAD_BEEF; be[k] = 4'hF;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out%0d", k), dout[k], 32'd0);
            chk($sformatf("rst_rdy%0d", k), {31'b0, rdy[k]}, 32'd0);
            chk($sformatf("rst_err%0d", k), {31'b0, err[k]}, 32'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        en[1] = 1'b0; en[2] = 1'b0;

        // one wait state: latency, byte enables, range error
        issue(0, 1, 16'd0, 32'd10, 4'hF, 32'd10, 0, 0);
        issue(0, 0, 16'd0, 32'd0, 4'hF, 32'd10, 0, 0);
        issue(0, 1, 16'd0, 32'hFFFF_FFFF, 4'h0, 32'd10, 0, 0);
        issue(0, 1, 16'd2, 32'h1122_3344, 4'hF, 32'h1122_3344, 0, 0);
        issue(0, 1, 16'd2, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 0, 0);
        issue(0, 0, 16'd2, 32'd0, 4'hF, 32'h11BB_33DD, 0, 0);
        issue(0, 1, 16'd999, 32'h0000_0999, 4'hF, 32'h0000_0999, 0, 0);
        issue(0, 1, 16'd1000, 32'd7, 4'hF, 32'd0, 1, 0);
        chk("post_rdy", {31'b0, rdy[0]}, 32'd0);
        chk("post_err", {31'b0, err[0]}, 32'd0);
        chk("post_out", dout[0], 32'd0);
        issue(0, 0, 16'd999, 32'd0, 4'hF, 32'h0000_0999, 0, 0);
        chk("hold_out", dout[0], 32'h0000_0999);
        issue(0, 0, 16'hFFFF, 32'd0, 4'hF, 32'd0, 1, 0);

        // three wait states: reset during the second WAIT cycle aborts the write
        issue(1, 1, 16'd1, 32'd0, 4'hF, 32'd0, 0, 0);
        en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'd1; din[1] = 32'h55; be[1] = 4'hF;
        @(posedge clk); #1;
        en[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        #2;
        chk("abort_rdy", {31'b0, rdy[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        repeat (8) @(negedge clk);
        issue(1, 0, 16'd1, 32'd0, 4'hF, 32'd0, 0, 0);

        // zero wait states: enable held, one response every two cycles
        issue(2, 1, 16'd0, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5, 0, 0);
        issue(2, 1, 16'd1, 32'h5A5A_5A5A, 4'hF, 32'h5A5A_5A5A, 0, 0);
        for (int r = 0; r < 4; r++) begin
            if (r[0]) issue(2, 0, 16'd1, 32'd0, 4'hF, 32'h5A5A_5A5A, 0, 1);
            else      issue(2, 0, 16'd0, 32'd0, 4'hF, 32'hA5A5_A5A5, 0, 1);
            if (r > 0) chk("spacing", last_acc - prev_acc, 32'd2);
        end
        en[2] = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
